// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller.
//   - state_t   : controller state encoding
//   - line field offsets (valid bit, first data bit)
//   - helper functions that derive tag width, words per line and packed line width
package cache_refill_ctrl_pkg;

  localparam int ADDR_W    = 32;
  localparam int VALID_BIT = 0;
  localparam int DATA_LSB  = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    CHECK   = 3'd2,
    FILL    = 3'd3,
    INSTALL = 3'd4,
    DONE    = 3'd5
  } state_t;

  function automatic int tag_bits(input int index_bits, input int block_offset);
    return ADDR_W - index_bits - block_offset;
  endfunction

  function automatic int words_per_line(input int block_offset);
    return 2 ** (block_offset - 2);
  endfunction

  function automatic int line_length(input int tag_w, input int wpl, input int word_w);
    return tag_w + wpl * word_w + 1;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_line_fill_buffer.sv
// Line fill buffer: beat counter plus the packed data words of one cache line.
//   clk, rst   : clock, async active-high reset (clears counter and data)
//   clr        : restart the fill at word 0
//   wr, wdata  : store wdata into word[cnt] and advance cnt (wraps after last word)
//   cnt        : index of the word the next beat fills
//   data       : packed words, word k at [k*WORD_SIZE +: WORD_SIZE]
//   last       : cnt points at the final word of the line
module line_fill_buffer #(
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 16,
  parameter int CNT_W          = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                wr,
  input  logic [WORD_SIZE-1:0]                wdata,
  output logic [CNT_W-1:0]                    cnt,
  output logic [WORDS_PER_LINE*WORD_SIZE-1:0] data,
  output logic                                last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (wr)  cnt <= cnt + 1'b1;
  end

  // Every word is overwritten before an install, so clr leaves the data alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     data <= '0;
    else if (wr) data[cnt*WORD_SIZE +: WORD_SIZE] <= wdata;
  end

  assign last = (cnt == CNT_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller in front of a direct-mapped cache array.
// Each CPU access goes LOOKUP -> CHECK; a hit finishes in DONE, a miss fills the
// line word by word from memory, installs it with a one-cycle full-line write and
// re-runs the lookup. The CPU is stalled for the whole access.
//   cpu_req/cpu_addr      : access request, sampled in IDLE only
//   cpu_stall/cpu_done    : stall while busy, one-cycle done pulse on hit
//   cache_enable/addr/hit : array lookup interface (hit is registered by the array)
//   cache_full_line_wr    : one-cycle install strobe, cache_new_line carries the line
//   mem_req/addr/ack/rdata: single-word read interface for the fill
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int INDEX_BITS     = 5,
  parameter int BLOCK_OFFSET   = 6,
  parameter int TAG_BITS       = tag_bits(INDEX_BITS, BLOCK_OFFSET),
  parameter int WORDS_PER_LINE = words_per_line(BLOCK_OFFSET),
  parameter int LINE_LENGTH    = line_length(TAG_BITS, WORDS_PER_LINE, WORD_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic [ADDR_W-1:0]      cpu_addr,
  output logic                   cpu_stall,
  output logic                   cpu_done,
  output logic                   cache_enable,
  output logic [ADDR_W-1:0]      cache_addr,
  input  logic                   cache_hit,
  output logic                   cache_full_line_wr,
  output logic [LINE_LENGTH-1:0] cache_new_line,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [WORD_SIZE-1:0]   mem_rdata
);

  localparam int CNT_W = BLOCK_OFFSET - 2;

  state_t                              state, state_nxt;
  logic [ADDR_W-1:0]                   addr_q;
  logic                                fill_clr, fill_wr, fill_last;
  logic [CNT_W-1:0]                    fill_cnt;
  logic [WORDS_PER_LINE*WORD_SIZE-1:0] fill_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cpu_req) addr_q <= cpu_addr;
    end
  end

  always_comb begin
    state_nxt          = state;
    cpu_stall          = 1'b0;
    cpu_done           = 1'b0;
    cache_enable       = 1'b0;
    cache_full_line_wr = 1'b0;
    mem_req            = 1'b0;
    fill_clr           = 1'b0;
    case (state)
      IDLE: if (cpu_req) state_nxt = LOOKUP;
      LOOKUP: begin
        cpu_stall    = 1'b1;
        cache_enable = 1'b1;
        state_nxt    = CHECK;
      end
      CHECK: begin
        cpu_stall    = 1'b1;
        cache_enable = 1'b1;
        if (cache_hit) begin
          state_nxt = DONE;
        end else begin
          fill_clr  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        if (mem_ack && fill_last) state_nxt = INSTALL;
      end
      INSTALL: begin
        cpu_stall          = 1'b1;
        cache_enable       = 1'b1;
        cache_full_line_wr = 1'b1;
        state_nxt          = LOOKUP;
      end
      DONE: begin
        cpu_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Acks outside FILL never reach the buffer.
  assign fill_wr = (state == FILL) && mem_ack;

  line_fill_buffer #(
    .WORD_SIZE      (WORD_SIZE),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .CNT_W          (CNT_W)
  ) u_fill (
    .clk   (clk),
    .rst   (rst),
    .clr   (fill_clr),
    .wr    (fill_wr),
    .wdata (mem_rdata),
    .cnt   (fill_cnt),
    .data  (fill_data),
    .last  (fill_last)
  );

  assign cache_addr = addr_q;
  assign mem_addr   = {addr_q[ADDR_W-1:BLOCK_OFFSET], fill_cnt, 2'b00};

  // Valid bit follows the install strobe so the whole image reads zero out of reset.
  assign cache_new_line = {addr_q[ADDR_W-1 -: TAG_BITS], fill_data, cache_full_line_wr};

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;
  import cache_refill_ctrl_pkg::*;

  localparam int WS   = 32;
  localparam int WPL  = 16;
  localparam int TAGW = 21;
  localparam int LL   = TAGW + WPL * WS + 1;
  localparam int CW   = 640;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [31:0]   cpu_addr;
  logic          cpu_stall, cpu_done, cache_enable, cache_hit, cache_full_line_wr;
  logic [31:0]   cache_addr, mem_addr;
  logic [LL-1:0] cache_new_line;
  logic          mem_req, mem_ack;
  logic [WS-1:0] mem_rdata;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_req            (cpu_req),
    .cpu_addr           (cpu_addr),
    .cpu_stall          (cpu_stall),
    .cpu_done           (cpu_done),
    .cache_enable       (cache_enable),
    .cache_addr         (cache_addr),
    .cache_hit          (cache_hit),
    .cache_full_line_wr (cache_full_line_wr),
    .cache_new_line     (cache_new_line),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata)
  );

  // Behavioural cache array: valid + tag per index, hit derived from the held address.
  logic            mvalid [32];
  logic [TAGW-1:0] mtag   [32];
  assign cache_hit = mvalid[cache_addr[10:6]] && (mtag[cache_addr[10:6]] == cache_addr[31:11]);

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [LL-1:0] exp_line(input logic [31:0] a, input logic [31:0] seed);
    logic [LL-1:0] l;
    l    = '0;
    l[0] = 1'b1;
    for (int k = 0; k < WPL; k++) l[1 + k*WS +: WS] = seed + 32'(k);
    l[LL-1 -: TAGW] = a[31:11];
    return l;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[10:6]] && (mtag[a[10:6]] == a[31:11]);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One full access. Called and returns at #1 after a posedge with the DUT in IDLE.
  // drop_n: number of installs the array ignores (forces a re-miss after INSTALL).
  task automatic access(input string nm, input logic [31:0] a, input int period,
                        input logic [31:0] seed, input bit spur, input int drop_n,
                        input int exp_lat, input int exp_req, input int exp_wr);
    int  done_cyc = -1, beat = 0, waitc = 0;
    int  stall_n = 0, en_n = 0, wr_n = 0, req_n = 0;
    bit  addr_bad = 0, hold_bad = 0;
    logic [LL-1:0] line_got = '0;
    logic [31:0]   base;
    base = a & 32'hFFFF_FFC0;
    cpu_req = 1'b1; cpu_addr = a; mem_ack = 1'b0; mem_rdata = '0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int cyc = 1; cyc <= 600 && done_cyc < 0; cyc++) begin
      if (spur) begin cpu_req = 1'($urandom_range(0, 1)); cpu_addr = $urandom; end
      if (cyc == exp_lat) cpu_req = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = spur ? $urandom : 32'h0;
      if (mem_req) begin
        req_n++;
        if (mem_addr !== base + 32'(4 * (beat % WPL))) addr_bad = 1;
        waitc++;
        if (waitc == period) begin
          mem_ack = 1'b1; mem_rdata = seed + 32'(beat); beat++; waitc = 0;
        end
      end else if (spur) begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (cache_addr !== a) hold_bad = 1;
      if (cpu_stall) stall_n++;
      if (cache_enable) en_n++;
      if (cache_full_line_wr) begin
        wr_n++;
        line_got = cache_new_line;
        if (wr_n > drop_n) begin mvalid[a[10:6]] = 1'b1; mtag[a[10:6]] = a[31:11]; end
      end
      if (cpu_done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; mem_ack = 1'b0;
    chk({nm, ".latency"}, CW'(done_cyc), CW'(exp_lat));
    chk({nm, ".idle_after_done"}, CW'({cpu_stall, cache_enable}), '0);
    chk({nm, ".stall_cycles"}, CW'(stall_n), CW'(exp_lat - 1));
    chk({nm, ".enable_cycles"}, CW'(en_n), CW'(2 + 3 * exp_wr));
    chk({nm, ".install_pulses"}, CW'(wr_n), CW'(exp_wr));
    chk({nm, ".mem_req_cycles"}, CW'(req_n), CW'(exp_req));
    chk({nm, ".mem_addr_seq"}, CW'(addr_bad), '0);
    chk({nm, ".cache_addr_held"}, CW'(hold_bad), '0);
    if (exp_wr > 0)
      chk({nm, ".line"}, CW'(line_got), CW'(exp_line(a, seed + 32'(WPL * (exp_wr - 1)))));
    if (done_cyc < 0) do_reset();
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          preload;
    int          period;
    logic [31:0] seed;
    bit          spur;
    int          exp_lat;
    int          exp_req;
    int          exp_wr;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int acks;
    logic [31:0] a;
    int  per, lat;
    bit  h;

    for (int i = 0; i < 32; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
    tbl[0] = '{32'h0000_0040, 1'b1, 1, 32'h0,         1'b0,  3,  0, 0};
    tbl[1] = '{32'h0000_1234, 1'b0, 1, 32'hA0,        1'b0, 22, 16, 1};
    tbl[2] = '{32'h0000_5678, 1'b0, 3, 32'hC000_0000, 1'b0, 54, 48, 1};
    tbl[3] = '{32'h0000_9ABC, 1'b0, 2, 32'h1111_0000, 1'b1, 38, 32, 1};

    // Reset asserted mid-cycle with random inputs: outputs clear without a clock edge.
    rst = 1'b0;
    cpu_req = 1'($urandom_range(0, 1)); cpu_addr = $urandom;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #2 rst = 1'b1;
    #1;
    chk("reset.outputs", CW'({cpu_stall, cpu_done, cache_enable, cache_full_line_wr, mem_req,
                             mem_addr, cache_addr, cache_new_line}), '0);
    @(posedge clk); #1;
    chk("reset.held_idle", CW'({cpu_stall, mem_req, cache_enable}), '0);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].preload) begin
        mvalid[tbl[i].addr[10:6]] = 1'b1;
        mtag[tbl[i].addr[10:6]]   = tbl[i].addr[31:11];
      end
      access($sformatf("vec%0d", i), tbl[i].addr, tbl[i].period, tbl[i].seed, tbl[i].spur, 0,
             tbl[i].exp_lat, tbl[i].exp_req, tbl[i].exp_wr);
    end

    // Array ignores the first install: CHECK misses again and a second fill must run.
    access("remiss", 32'h0000_2300, 1, 32'h7700_0000, 1'b0, 1, 41, 32, 2);

    // Reset after five fill beats.
    a = 32'h0000_3340;
    cpu_req = 1'b1; cpu_addr = a;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 40 && acks < 5; c++) begin
      mem_ack = mem_req; mem_rdata = 32'hDEAD_0000 + 32'(acks);
      if (mem_req) acks++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    chk("midfill.mem_req_before", CW'(mem_req), CW'(1));
    chk("midfill.mem_addr_before", CW'(mem_addr), CW'(32'h0000_3354));
    #2 rst = 1'b1;
    #1;
    chk("midfill.outputs_cleared", CW'({cpu_stall, cpu_done, cache_enable, cache_full_line_wr,
                                       mem_req, mem_addr, cache_new_line}), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midfill.no_install", CW'({cache_full_line_wr, mem_req, cpu_stall}), '0);
    access("refill", a, 1, 32'h5500_0000, 1'b0, 0, 22, 16, 1);

    // Randomized accesses against the behavioural cache model.
    for (int i = 0; i < 24; i++) begin
      a = (32'($urandom_range(0, 2)) << 11) | (32'($urandom_range(0, 3)) << 6) | ($urandom & 32'h3F);
      per = $urandom_range(1, 3);
      h = model_hit(a);
      lat = h ? 3 : 6 + WPL * per;
      access($sformatf("rand%0d", i), a, per, $urandom, 1'($urandom_range(0, 1)), 0,
             lat, h ? 0 : WPL * per, h ? 0 : 1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr + 1);
    $fatal(1, "watchdog");
  end

endmodule
